// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ALU micro-ops until their consumed
// operands are present, snoops the CDB for wakeup, and issues the lowest ready entry.

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_SRC1_SEL
`define ALU_SRC1_SEL 2
`endif
`ifndef ALU_SRC2_SEL
`define ALU_SRC2_SEL 2
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif
`ifndef ALU_SRC1_RS1
`define ALU_SRC1_RS1 2'd0
`endif
`ifndef ALU_SRC2_RS2
`define ALU_SRC2_RS2 2'd0
`endif

// state    | meaning
// ST_FREE  | slot empty, may accept a dispatch
// ST_WAIT  | holds a micro-op with at least one needed operand outstanding
// ST_READY | every needed operand captured, eligible for issue
module alu_rs #(
  parameter int ENTRIES   = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_flush,
  input  logic                          i_dp_valid,
  output logic                          o_dp_ready,
  input  logic [`ALU_OP_WIDTH-1:0]      i_dp_op,
  input  logic [`ALU_SRC1_SEL-1:0]      i_dp_src1_sel,
  input  logic [`ALU_SRC2_SEL-1:0]      i_dp_src2_sel,
  input  logic [`RV32_PC_WIDTH-1:0]     i_dp_pc,
  input  logic [31:0]                   i_dp_imm,
  input  logic                          i_dp_rs1_rdy,
  input  logic                          i_dp_rs2_rdy,
  input  logic [31:0]                   i_dp_rs1_data,
  input  logic [31:0]                   i_dp_rs2_data,
  input  logic [TAG_WIDTH-1:0]          i_dp_rs1_tag,
  input  logic [TAG_WIDTH-1:0]          i_dp_rs2_tag,
  input  logic [TAG_WIDTH-1:0]          i_dp_rd_tag,
  input  logic                          i_cdb_valid,
  input  logic [TAG_WIDTH-1:0]          i_cdb_tag,
  input  logic [31:0]                   i_cdb_data,
  output logic                          o_is_valid,
  input  logic                          i_is_ready,
  output logic [`ALU_OP_WIDTH-1:0]      o_is_op,
  output logic [`ALU_SRC1_SEL-1:0]      o_is_src1_sel,
  output logic [`ALU_SRC2_SEL-1:0]      o_is_src2_sel,
  output logic [`RV32_PC_WIDTH-1:0]     o_is_pc,
  output logic [31:0]                   o_is_imm,
  output logic [31:0]                   o_is_rs1,
  output logic [31:0]                   o_is_rs2,
  output logic [TAG_WIDTH-1:0]          o_is_rd_tag
);

  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ent_state_e;

  typedef struct packed {
    logic [`ALU_OP_WIDTH-1:0]  op;
    logic [`ALU_SRC1_SEL-1:0]  src1_sel;
    logic [`ALU_SRC2_SEL-1:0]  src2_sel;
    logic [`RV32_PC_WIDTH-1:0] pc;
    logic [31:0]               imm;
    logic                      rs1_rdy;
    logic [TAG_WIDTH-1:0]      rs1_tag;
    logic [31:0]               rs1_data;
    logic                      rs2_rdy;
    logic [TAG_WIDTH-1:0]      rs2_tag;
    logic [31:0]               rs2_data;
    logic [TAG_WIDTH-1:0]      rd_tag;
  } ent_t;

  ent_state_e st_q [ENTRIES];
  ent_state_e st_d [ENTRIES];
  ent_t       ent_q [ENTRIES];
  ent_t       ent_d [ENTRIES];

  logic            rst_meta_q;
  logic            rst_sync_n_q;
  logic            free_any;
  logic [IDXW-1:0] free_idx;
  logic            is_any;
  logic [IDXW-1:0] is_idx;
  logic            dp_need1;
  logic            dp_need2;
  logic            dp_byp1;
  logic            dp_byp2;
  ent_t            dp_ent;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    is_any   = 1'b0;
    is_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        free_any = 1'b1;
        free_idx = IDXW'(i);
      end
      if (st_q[i] == ST_READY) begin
        is_any = 1'b1;
        is_idx = IDXW'(i);
      end
    end
  end

  // Dispatch entry with CDB bypass; an operand the selectors ignore is marked present.
  always_comb begin
    dp_need1 = (i_dp_src1_sel == `ALU_SRC1_RS1);
    dp_need2 = (i_dp_src2_sel == `ALU_SRC2_RS2);
    dp_byp1  = dp_need1 && !i_dp_rs1_rdy && i_cdb_valid && (i_dp_rs1_tag == i_cdb_tag);
    dp_byp2  = dp_need2 && !i_dp_rs2_rdy && i_cdb_valid && (i_dp_rs2_tag == i_cdb_tag);
    dp_ent          = '0;
    dp_ent.op       = i_dp_op;
    dp_ent.src1_sel = i_dp_src1_sel;
    dp_ent.src2_sel = i_dp_src2_sel;
    dp_ent.pc       = i_dp_pc;
    dp_ent.imm      = i_dp_imm;
    dp_ent.rs1_rdy  = !dp_need1 || i_dp_rs1_rdy || dp_byp1;
    dp_ent.rs1_tag  = i_dp_rs1_tag;
    dp_ent.rs1_data = dp_byp1 ? i_cdb_data : i_dp_rs1_data;
    dp_ent.rs2_rdy  = !dp_need2 || i_dp_rs2_rdy || dp_byp2;
    dp_ent.rs2_tag  = i_dp_rs2_tag;
    dp_ent.rs2_data = dp_byp2 ? i_cdb_data : i_dp_rs2_data;
    dp_ent.rd_tag   = i_dp_rd_tag;
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      st_d[i]  = st_q[i];
      ent_d[i] = ent_q[i];
    end

    for (int i = 0; i < ENTRIES; i++) begin
      if (st_q[i] == ST_WAIT) begin
        if (!ent_q[i].rs1_rdy && i_cdb_valid && (ent_q[i].rs1_tag == i_cdb_tag)) begin
          ent_d[i].rs1_rdy  = 1'b1;
          ent_d[i].rs1_data = i_cdb_data;
        end
        if (!ent_q[i].rs2_rdy && i_cdb_valid && (ent_q[i].rs2_tag == i_cdb_tag)) begin
          ent_d[i].rs2_rdy  = 1'b1;
          ent_d[i].rs2_data = i_cdb_data;
        end
        if (ent_d[i].rs1_rdy && ent_d[i].rs2_rdy) begin
          st_d[i] = ST_READY;
        end
      end
    end

    if (is_any && i_is_ready) begin
      st_d[is_idx] = ST_FREE;
    end

    // free_idx comes from registered state, so a slot freed by issue above is never reused here.
    if (i_dp_valid && free_any) begin
      ent_d[free_idx] = dp_ent;
      st_d[free_idx]  = (dp_ent.rs1_rdy && dp_ent.rs2_rdy) ? ST_READY : ST_WAIT;
    end

    if (i_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        st_d[i] = ST_FREE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      for (int i = 0; i < ENTRIES; i++) begin
        st_q[i]  <= ST_FREE;
        ent_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        st_q[i]  <= st_d[i];
        ent_q[i] <= ent_d[i];
      end
    end
  end

  always_comb begin
    o_dp_ready    = free_any;
    o_is_valid    = is_any;
    o_is_op       = '0;
    o_is_src1_sel = '0;
    o_is_src2_sel = '0;
    o_is_pc       = '0;
    o_is_imm      = '0;
    o_is_rs1      = '0;
    o_is_rs2      = '0;
    o_is_rd_tag   = '0;
    if (is_any) begin
      o_is_op       = ent_q[is_idx].op;
      o_is_src1_sel = ent_q[is_idx].src1_sel;
      o_is_src2_sel = ent_q[is_idx].src2_sel;
      o_is_pc       = ent_q[is_idx].pc;
      o_is_imm      = ent_q[is_idx].imm;
      o_is_rs1      = ent_q[is_idx].rs1_data;
      o_is_rs2      = ent_q[is_idx].rs2_data;
      o_is_rd_tag   = ent_q[is_idx].rd_tag;
    end
  end

endmodule
